// File: rtl/fifo_if_host.sv
// fifo_if_host_fifo: small first-word-fall-through FIFO with occupancy count.
// Latency: a pushed word is visible at head_dat the cycle after the push edge.
// Backpressure: none internally; the caller must not push when level == DEPTH.
module fifo_if_host_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_vld,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop_rdy,
  output logic                   head_vld,
  output logic [W-1:0]           head_dat,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;

  assign head_vld = (level != '0);
  assign head_dat = mem[rd_ptr];
  assign do_pop   = pop_rdy && head_vld;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_vld) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_vld, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset; an entry is only read once it has been written.
  always_ff @(posedge clk_i) begin
    if (push_vld) begin
      mem[wr_ptr] <= push_dat;
    end
  end

endmodule

// fifo_if_host: bus master standing in for the MCU on the fifo_if register port.
// Latency: >=4 cycles per received byte after leaving IDLE, >=3 cycles per sent byte.
// Backpressure: RX polling pauses while the RX FIFO is full; tx_ready_o is low while the holding byte waits.
module fifo_if_host #(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   sel_o,
  output logic                   read_o,
  output logic                   write_o,
  output logic [1:0]             addr_o,
  output logic [7:0]             data_o,
  input  logic [7:0]             data_i,
  input  logic                   in_irq_i,
  input  logic                   out_irq_i,
  output logic [7:0]             rx_data_o,
  output logic                   rx_valid_o,
  input  logic                   rx_ready_i,
  input  logic [7:0]             tx_data_i,
  input  logic                   tx_valid_i,
  output logic                   tx_ready_o,
  output logic [$clog2(DEPTH):0] rx_level_o
);

  localparam int AW = $clog2(DEPTH);

  // fifo_if register addresses
  localparam logic [1:0] ADDR_IN       = 2'b01;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b10;
  localparam logic [1:0] ADDR_OUT_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RX_STAT,
    RX_STAT_CHK,
    RX_DATA,
    RX_CAP,
    TX_STAT,
    TX_STAT_CHK,
    TX_WR
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       prio_tx;
  logic       prio_tx_nxt;
  logic       pick_tx;
  logic       rx_elig;
  logic       tx_elig;
  logic       rx_push;
  logic [7:0] hold_dat;

  // Level equals DEPTH exactly when its top bit is set, so RX may run while it is clear.
  // Only one RX transaction is ever in flight, so this reserves the slot before the data read.
  assign rx_elig = !rx_level_o[AW];
  assign tx_elig = !tx_ready_o;

  // Receive FIFO; data_i is pushed in RX_CAP, one cycle after the OUT data read.
  fifo_if_host_fifo #(
    .W     (8),
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_vld (rx_push),
    .push_dat (data_i),
    .pop_rdy  (rx_ready_i),
    .head_vld (rx_valid_o),
    .head_dat (rx_data_o),
    .level    (rx_level_o)
  );

  // TX holding register: freed by the IN write; a new byte can only land from the next cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_ready_o <= 1'b1;
      hold_dat   <= 8'h00;
    end else if (state == TX_WR) begin
      tx_ready_o <= 1'b1;
    end else if (tx_valid_i && tx_ready_o) begin
      tx_ready_o <= 1'b0;
      hold_dat   <= tx_data_i;
    end
  end

  // State and round-robin priority registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      prio_tx <= 1'b0;
    end else begin
      state   <= state_nxt;
      prio_tx <= prio_tx_nxt;
    end
  end

  // Arbitration choice when both paths are eligible; a lone IRQ hint overrides round-robin.
  always_comb begin
    pick_tx = prio_tx;
    if (out_irq_i && !in_irq_i) begin
      pick_tx = 1'b0;
    end else if (in_irq_i && !out_irq_i) begin
      pick_tx = 1'b1;
    end
  end

  // Next state, bus strobes and FIFO push; priority flips to the other path after every transaction.
  always_comb begin
    state_nxt   = state;
    prio_tx_nxt = prio_tx;
    sel_o       = 1'b0;
    read_o      = 1'b0;
    write_o     = 1'b0;
    addr_o      = 2'b00;
    data_o      = 8'h00;
    rx_push     = 1'b0;
    case (state)
      IDLE: begin
        if (rx_elig && (!tx_elig || !pick_tx)) begin
          state_nxt = RX_STAT;
        end else if (tx_elig) begin
          state_nxt = TX_STAT;
        end
      end
      RX_STAT: begin
        sel_o     = 1'b1;
        read_o    = 1'b1;
        addr_o    = ADDR_OUT_STAT;
        state_nxt = RX_STAT_CHK;
      end
      RX_STAT_CHK: begin
        if (data_i[0]) begin
          state_nxt = RX_DATA;
        end else begin
          state_nxt   = IDLE;
          prio_tx_nxt = 1'b1;
        end
      end
      RX_DATA: begin
        // This read also re-arms the fifo_if OUT side.
        sel_o     = 1'b1;
        read_o    = 1'b1;
        addr_o    = ADDR_OUT_DATA;
        state_nxt = RX_CAP;
      end
      RX_CAP: begin
        rx_push     = 1'b1;
        state_nxt   = IDLE;
        prio_tx_nxt = 1'b1;
      end
      TX_STAT: begin
        sel_o     = 1'b1;
        read_o    = 1'b1;
        addr_o    = ADDR_IN;
        state_nxt = TX_STAT_CHK;
      end
      TX_STAT_CHK: begin
        state_nxt   = data_i[0] ? TX_WR : IDLE;
        prio_tx_nxt = data_i[0] ? prio_tx : 1'b0;
      end
      TX_WR: begin
        sel_o       = 1'b1;
        write_o     = 1'b1;
        addr_o      = ADDR_IN;
        data_o      = hold_dat;
        state_nxt   = IDLE;
        prio_tx_nxt = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_if_host.sv
// Testbench for fifo_if_host: behavioural fifo_if register model plus RX/TX scoreboards.
module tb_fifo_if_host;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          sel_o, read_o, write_o;
  logic [1:0]    addr_o;
  logic [7:0]    data_o, data_i;
  logic          in_irq_i, out_irq_i;
  logic [7:0]    rx_data_o;
  logic          rx_valid_o, rx_ready_i;
  logic [7:0]    tx_data_i;
  logic          tx_valid_i, tx_ready_o;
  logic [LW-1:0] rx_level_o;

  always #5 clk_i = ~clk_i;

  fifo_if_host #(.DEPTH(DEPTH)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .sel_o      (sel_o),
    .read_o     (read_o),
    .write_o    (write_o),
    .addr_o     (addr_o),
    .data_o     (data_o),
    .data_i     (data_i),
    .in_irq_i   (in_irq_i),
    .out_irq_i  (out_irq_i),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .rx_ready_i (rx_ready_i),
    .tx_data_i  (tx_data_i),
    .tx_valid_i (tx_valid_i),
    .tx_ready_o (tx_ready_o),
    .rx_level_o (rx_level_o)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // fifo_if model state and scoreboards
  logic [7:0] out_q[$];
  logic [7:0] rx_exp[$];
  logic [7:0] tx_exp[$];
  int         log_q[$];
  bit         log_en;
  int         in_busy, in_busy_load;
  int         cnt_rd01 = 0, cnt_rd10 = 0, cnt_rd11 = 0, cnt_wr01 = 0;
  int         t_hit10 = -1, t_rd11 = -1;
  int         rx_got = 0;
  logic [7:0] resp;
  logic       bus_bad;

  typedef struct {
    bit         is_tx;
    logic [7:0] dat;
    logic [7:0] exp_dat;
    int         exp_level;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out, required event never occurred", name);
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // fifo_if register model: sees strobes mid-cycle, returns read data for the whole next cycle.
  always @(negedge clk_i) begin
    resp = 8'hEE;
    bus_bad = (read_o && write_o) || (sel_o !== (read_o || write_o)) ||
              (!(read_o || write_o) && (addr_o != 2'b00 || data_o != 8'h00));
    check("bus_rules", {31'd0, bus_bad}, 32'd0);
    if (read_o) begin
      case (addr_o)
        2'b01: begin
          resp = {7'd0, in_busy == 0};
          cnt_rd01++;
          if (log_en) log_q.push_back(1);
        end
        2'b10: begin
          resp = {7'd0, out_q.size() != 0};
          cnt_rd10++;
          if (out_q.size() != 0) t_hit10 = cyc;
          if (log_en) log_q.push_back(0);
        end
        2'b11: begin
          cnt_rd11++;
          t_rd11 = cyc;
          if (out_q.size() != 0) resp = out_q.pop_front();
          else timeout("rd11_without_out_byte");
        end
        default: check("read_addr", {30'd0, addr_o}, 32'd1);
      endcase
    end
    if (write_o) begin
      cnt_wr01++;
      check("write_addr", {30'd0, addr_o}, 32'd1);
      check("write_in_empty", in_busy, 0);
      if (tx_exp.size() == 0) timeout("unexpected_in_write");
      else check("tx_byte", {24'd0, data_o}, {24'd0, tx_exp.pop_front()});
      in_busy = in_busy_load;
    end else if (in_busy > 0) begin
      in_busy--;
    end
    @(posedge clk_i);
    #1 data_i = resp;
  end

  // RX consumer: compare every popped byte against the scoreboard.
  always @(negedge clk_i) begin
    if (!rst_i && rx_valid_o && rx_ready_i) begin
      rx_got++;
      if (rx_exp.size() == 0) timeout("rx_unexpected_pop");
      else check("rx_order", {24'd0, rx_data_o}, {24'd0, rx_exp.pop_front()});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send_tx(input logic [7:0] b, input bit track);
    int k = 0;
    tx_data_i  = b;
    tx_valid_i = 1'b1;
    @(negedge clk_i);
    while (!tx_ready_o && k < 400) begin
      @(negedge clk_i);
      k++;
    end
    if (!tx_ready_o) timeout("tx_handshake");
    else if (track) tx_exp.push_back(b);
    @(posedge clk_i);
    #1 tx_valid_i = 1'b0;
  endtask

  task automatic wait_wr(input int target, input string name);
    int k = 0;
    while (cnt_wr01 < target && k < 400) begin step(1); k++; end
    if (cnt_wr01 < target) timeout(name);
  endtask

  task automatic wait_level(input int lvl, input string name);
    int k = 0;
    while (int'(rx_level_o) != lvl && k < 400) begin step(1); k++; end
    if (int'(rx_level_o) != lvl) timeout(name);
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!rx_valid_o && k < 400) begin step(1); k++; end
    if (!rx_valid_o) timeout(name);
  endtask

  task automatic wait_rd11(input string name);
    int k = 0;
    while (!(read_o && addr_o == 2'b11) && k < 400) begin step(1); k++; end
    if (!(read_o && addr_o == 2'b11)) timeout(name);
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while ((rx_exp.size() != 0 || out_q.size() != 0) && k < 600) begin step(1); k++; end
    if (rx_exp.size() != 0 || out_q.size() != 0) timeout(name);
  endtask

  initial begin
    int base, base2, t_v, bad;
    rst_i = 1'b1; in_irq_i = 1'b0; out_irq_i = 1'b0; rx_ready_i = 1'b0;
    tx_data_i = 8'h00; tx_valid_i = 1'b0; data_i = 8'hEE;
    in_busy = 0; in_busy_load = 0; log_en = 1'b0;
    vecs[0] = '{1'b0, 8'h5A, 8'h5A, 1};
    vecs[1] = '{1'b1, 8'hC3, 8'hC3, 0};
    vecs[2] = '{1'b0, 8'h00, 8'h00, 1};
    vecs[3] = '{1'b1, 8'hFF, 8'hFF, 0};
    vecs[4] = '{1'b0, 8'h81, 8'h81, 1};
    vecs[5] = '{1'b1, 8'h01, 8'h01, 0};

    // Reset state
    step(3);
    check("rst_sel", sel_o, 0);
    check("rst_read", read_o, 0);
    check("rst_write", write_o, 0);
    check("rst_addr", addr_o, 0);
    check("rst_data", data_o, 0);
    check("rst_rx_valid", rx_valid_o, 0);
    check("rst_tx_ready", tx_ready_o, 1);
    check("rst_rx_level", rx_level_o, 0);
    rst_i = 1'b0;
    step(2);

    // Table-driven single transactions
    for (int i = 0; i < 6; i++) begin
      if (!vecs[i].is_tx) begin
        out_q.push_back(vecs[i].dat);
        rx_exp.push_back(vecs[i].exp_dat);
        wait_valid("vec_rx_valid");
        check("vec_rx_data", rx_data_o, vecs[i].exp_dat);
        check("vec_rx_level", rx_level_o, vecs[i].exp_level);
        rx_ready_i = 1'b1;
        step(1);
        rx_ready_i = 1'b0;
        check("vec_rx_level_after_pop", rx_level_o, 0);
      end else begin
        base = cnt_wr01;
        send_tx(vecs[i].dat, 1'b0);
        tx_exp.push_back(vecs[i].exp_dat);
        wait_wr(base + 1, "vec_tx_write");
        check("vec_tx_sent_all", tx_exp.size(), 0);
        check("vec_tx_ready_back", tx_ready_o, 1);
      end
    end

    // 0xA5 receive latency
    t_hit10 = -1;
    out_q.push_back(8'hA5);
    rx_exp.push_back(8'hA5);
    wait_valid("a5_valid");
    t_v = cyc;
    check("a5_valid_latency", t_v - t_hit10, 4);
    check("a5_rd11_after_stat", t_rd11 - t_hit10, 2);
    check("a5_data", rx_data_o, 8'hA5);
    check("a5_level", rx_level_o, 1);
    rx_ready_i = 1'b1;
    step(1);
    rx_ready_i = 1'b0;

    // Fill to DEPTH with 6 bytes offered and the consumer stalled
    base = cnt_rd11;
    for (int i = 1; i <= 6; i++) begin
      out_q.push_back(8'(i));
      rx_exp.push_back(8'(i));
    end
    step(80);
    check("full_rd11_count", cnt_rd11 - base, DEPTH);
    check("full_level", rx_level_o, DEPTH);
    check("full_out_left", out_q.size(), 2);
    check("full_head", rx_data_o, 8'h01);
    base = rx_got;
    rx_ready_i = 1'b1;
    wait_drain("full_drain");
    step(4);
    check("full_delivered", rx_got - base, 6);
    rx_ready_i = 1'b0;

    // TX against a busy IN buffer
    in_busy = 10;
    base  = cnt_rd01;
    base2 = cnt_wr01;
    send_tx(8'h3C, 1'b1);
    wait_wr(base2 + 1, "busy_tx_write");
    check("busy_multi_poll", (cnt_rd01 - base) > 1, 1);
    check("busy_tx_done", tx_exp.size(), 0);
    check("busy_tx_ready_back", tx_ready_o, 1);

    // Continuous RX and TX: transactions alternate
    rx_ready_i = 1'b1;
    base = cnt_wr01;
    for (int i = 0; i < 20; i++) begin
      out_q.push_back(8'(i * 7 + 3));
      rx_exp.push_back(8'(i * 7 + 3));
    end
    fork
      for (int i = 0; i < 12; i++) send_tx(8'(i * 13 + 5), 1'b1);
      begin
        wait_wr(base + 1, "alt_first_write");
        log_q.delete();
        log_en = 1'b1;
      end
    join
    log_en = 1'b0;
    bad = 0;
    for (int i = 1; i < log_q.size(); i++) if (log_q[i] == log_q[i-1]) bad++;
    check("alt_strict", bad, 0);
    check("alt_enough", log_q.size() >= 10, 1);
    wait_wr(base + 12, "alt_all_written");
    wait_drain("alt_drain");
    rx_ready_i = 1'b0;

    // Push and pop in the same cycle at level 2
    out_q.push_back(8'h11); rx_exp.push_back(8'h11);
    out_q.push_back(8'h22); rx_exp.push_back(8'h22);
    wait_level(2, "pp_level2");
    out_q.push_back(8'hFF); rx_exp.push_back(8'hFF);
    wait_rd11("pp_rd11");
    step(1);
    rx_ready_i = 1'b1;
    check("pp_level_before", rx_level_o, 2);
    step(1);
    rx_ready_i = 1'b0;
    check("pp_level_after", rx_level_o, 2);
    check("pp_head", rx_data_o, 8'h22);
    out_q.push_back(8'h00); rx_exp.push_back(8'h00);
    wait_level(3, "pp_level3");
    rx_ready_i = 1'b1;
    wait_drain("pp_drain");
    step(2);
    check("pp_level_empty", rx_level_o, 0);
    rx_ready_i = 1'b0;

    // Reset in RX_DATA with a full holding register and a non-empty FIFO
    in_busy = 1000;
    send_tx(8'h5A, 1'b0);
    out_q.push_back(8'h33); rx_exp.push_back(8'h33);
    wait_level(1, "rst_pre_level");
    out_q.push_back(8'h77);
    wait_rd11("rst_rd11");
    rst_i = 1'b1;
    step(1);
    check("mid_rst_strobes", {sel_o, read_o, write_o}, 0);
    check("mid_rst_rx_valid", rx_valid_o, 0);
    check("mid_rst_tx_ready", tx_ready_o, 1);
    check("mid_rst_level", rx_level_o, 0);
    rx_exp.delete();
    tx_exp.delete();
    in_busy = 0;
    step(1);
    rst_i = 1'b0;
    step(20);
    check("post_rst_level", rx_level_o, 0);
    check("post_rst_tx_ready", tx_ready_o, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    timeout("watchdog");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
